// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: fetch PC sequencing, redirects and
// single-outstanding instruction-memory handshake feeding the IF/ID register.
module pc_fetch_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  pc_src_in,
  input  logic        flush_in,
  input  logic [31:0] trap_vector_in,
  input  logic [31:0] epc_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        misaligned_instr_out
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;

  logic        redirect;
  logic        out_free;
  logic        req;
  logic [31:0] target;

  // Redirects have no effect while the boot cycle is in progress
  assign redirect = (state_q != S_BOOT) &&
                    (flush_in || branch_taken_in);
  assign out_free = !valid_q || !stall_in;

  always_comb begin
    target = branch_target_in;
    if (flush_in) begin
      unique case (pc_src_in)
        2'b00: target = BOOT_ADDR;
        2'b01: target = fpc_q;
        2'b10: target = trap_vector_in;
        2'b11: target = epc_in;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q && stall_in;
    kill_d  = kill_q;
    req     = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        fpc_d   = BOOT_ADDR;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (fpc_q[1:0] != 2'b00) begin
          state_d = S_FAULT;
          valid_d = 1'b0;
        end else begin
          req = out_free;
          if (req && imem_ready_in) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_in) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect) begin
            instr_d = imem_rdata_in;
            pc_d    = fpc_q;
            valid_d = 1'b1;
            fpc_d   = fpc_q + 32'd4;
          end
        end
      end
      S_FAULT: begin
        valid_d = 1'b0;
      end
    endcase
    if (redirect) begin
      fpc_d   = target;
      valid_d = 1'b0;
      // A response is still owed: stay in WAIT and drop it on arrival
      if (state_q == S_WAIT && !imem_rvalid_in) begin
        kill_d = 1'b1;
      end else if (req && imem_ready_in) begin
        state_d = S_WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_BOOT;
      fpc_q   <= BOOT_ADDR;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
    end
  end

  assign imem_req_out         = req;
  assign imem_addr_out        = fpc_q;
  assign instr_out            = instr_q;
  assign pc_out               = pc_q;
  assign instr_valid_out      = valid_q;
  assign misaligned_instr_out = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_pc_fetch_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  pc_src_in;
  logic        flush_in;
  logic [31:0] trap_vector_in;
  logic [31:0] epc_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        stall_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        misaligned_instr_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pc_fetch_stage dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pc_src_in            (pc_src_in),
    .flush_in             (flush_in),
    .trap_vector_in       (trap_vector_in),
    .epc_in               (epc_in),
    .branch_taken_in      (branch_taken_in),
    .branch_target_in     (branch_target_in),
    .stall_in             (stall_in),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .imem_ready_in        (imem_ready_in),
    .imem_rvalid_in       (imem_rvalid_in),
    .imem_rdata_in        (imem_rdata_in),
    .instr_out            (instr_out),
    .pc_out               (pc_out),
    .instr_valid_out      (instr_valid_out),
    .misaligned_instr_out (misaligned_instr_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    pc_src_in        = 2'b00;
    flush_in         = 1'b0;
    trap_vector_in   = 32'h0;
    epc_in           = 32'h0;
    branch_taken_in  = 1'b0;
    branch_target_in = 32'h0;
    stall_in         = 1'b0;
    imem_ready_in    = 1'b0;
    imem_rvalid_in   = 1'b0;
    imem_rdata_in    = 32'h0;
  endtask

  // Leaves the bench 1ns into the BOOT cycle
  task automatic apply_reset();
    rst_in = 1'b0;
    clear_inputs();
    step();
    step();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    clear_inputs();
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'hFFFF_FFFF;
    imem_ready_in  = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b exp=0", imem_req_out);
    end
    checks++;
    if (imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_addr got=%h exp=0", imem_addr_out);
    end
    checks++;
    if ({instr_valid_out, misaligned_instr_out} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags got=%b%b exp=00",
               instr_valid_out, misaligned_instr_out);
    end
    checks++;
    if (instr_out !== 32'h0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_regs got=%h/%h exp=0/0", instr_out, pc_out);
    end
    clear_inputs();
    rst_in = 1'b1;
    #1;
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL boot_noreq got=%b exp=0", imem_req_out);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    step();
    imem_ready_in = 1'b1;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL basic_req1 got=%b/%h exp=1/0",
               imem_req_out, imem_addr_out);
    end
    step();
    imem_ready_in  = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'h0000_0013;
    #1;
    checks++;
    if (imem_req_out !== 1'b0 || instr_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait got=%b/%b exp=0/0",
               imem_req_out, instr_valid_out);
    end
    step();
    imem_rvalid_in = 1'b0;
    #1;
    checks++;
    if (instr_valid_out !== 1'b1 || instr_out !== 32'h13) begin
      errors++;
      $display("FAIL basic_instr got=%b/%h exp=1/00000013",
               instr_valid_out, instr_out);
    end
    checks++;
    if (pc_out !== 32'h0) begin
      errors++;
      $display("FAIL basic_pc got=%h exp=0", pc_out);
    end
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h4) begin
      errors++;
      $display("FAIL basic_req2 got=%b/%h exp=1/4",
               imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step();
    imem_ready_in = 1'b1;
    step();
    imem_ready_in  = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'hAABB_CCDD;
    step();
    imem_rvalid_in = 1'b0;
    stall_in       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (instr_out !== 32'hAABB_CCDD || pc_out !== 32'h0 ||
          instr_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%h/%h/%b exp=aabbccdd/0/1",
                 i, instr_out, pc_out, instr_valid_out);
      end
      checks++;
      if (imem_req_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_noreq[%0d] got=%b exp=0", i, imem_req_out);
      end
      step();
    end
    stall_in = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h4) begin
      errors++;
      $display("FAIL stall_release got=%b/%h exp=1/4",
               imem_req_out, imem_addr_out);
    end
    step();
    #1;
    checks++;
    if (instr_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got=%b exp=0", instr_valid_out);
    end
  endtask

  task automatic test_flush_wait();
    apply_reset();
    step();
    imem_ready_in = 1'b1;
    step();
    imem_ready_in  = 1'b0;
    flush_in       = 1'b1;
    pc_src_in      = 2'b10;
    trap_vector_in = 32'h100;
    step();
    flush_in       = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (imem_req_out !== 1'b0 || instr_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill got=%b/%b exp=0/0",
               imem_req_out, instr_valid_out);
    end
    step();
    imem_rvalid_in = 1'b0;
    #1;
    checks++;
    if (instr_valid_out !== 1'b0 || instr_out !== 32'h0) begin
      errors++;
      $display("FAIL flush_discard got=%b/%h exp=0/0",
               instr_valid_out, instr_out);
    end
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin
      errors++;
      $display("FAIL flush_target got=%b/%h exp=1/100",
               imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    step();
    flush_in         = 1'b1;
    branch_taken_in  = 1'b1;
    pc_src_in        = 2'b11;
    epc_in           = 32'h200;
    branch_target_in = 32'h300;
    step();
    flush_in        = 1'b0;
    branch_taken_in = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200) begin
      errors++;
      $display("FAIL prio_epc got=%b/%h exp=1/200",
               imem_req_out, imem_addr_out);
    end
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h40;
    step();
    branch_taken_in = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h40) begin
      errors++;
      $display("FAIL prio_branch got=%b/%h exp=1/40",
               imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    step();
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h102;
    step();
    branch_taken_in = 1'b0;
    imem_ready_in   = 1'b1;
    #1;
    checks++;
    if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h102) begin
      errors++;
      $display("FAIL mis_noreq got=%b/%h exp=0/102",
               imem_req_out, imem_addr_out);
    end
    step();
    #1;
    checks++;
    if (misaligned_instr_out !== 1'b1 || imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL mis_fault got=%b/%b exp=1/0",
               misaligned_instr_out, imem_req_out);
    end
    step();
    #1;
    checks++;
    if (misaligned_instr_out !== 1'b1 || instr_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mis_held got=%b/%b exp=1/0",
               misaligned_instr_out, instr_valid_out);
    end
    imem_ready_in = 1'b0;
    flush_in      = 1'b1;
    pc_src_in     = 2'b00;
    step();
    flush_in = 1'b0;
    #1;
    checks++;
    if (misaligned_instr_out !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear got=%b exp=0", misaligned_instr_out);
    end
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL mis_boot got=%b/%h exp=1/0",
               imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step();
    branch_taken_in  = 1'b1;
    branch_target_in = 32'hFFFF_FFFC;
    step();
    branch_taken_in = 1'b0;
    imem_ready_in   = 1'b1;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req got=%b/%h exp=1/fffffffc",
               imem_req_out, imem_addr_out);
    end
    step();
    imem_ready_in  = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'h0000_1234;
    step();
    imem_rvalid_in = 1'b0;
    #1;
    checks++;
    if (pc_out !== 32'hFFFF_FFFC || instr_out !== 32'h1234) begin
      errors++;
      $display("FAIL wrap_out got=%h/%h exp=fffffffc/00001234",
               pc_out, instr_out);
    end
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next got=%b/%h exp=1/0",
               imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_boot_flush();
    apply_reset();
    flush_in       = 1'b1;
    pc_src_in      = 2'b10;
    trap_vector_in = 32'h100;
    step();
    flush_in       = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'h5555_5555;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL boot_flush got=%b/%h exp=1/0",
               imem_req_out, imem_addr_out);
    end
    step();
    imem_rvalid_in = 1'b0;
    #1;
    checks++;
    if (instr_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stray_rvalid got=%b exp=0", instr_valid_out);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step();
    imem_ready_in = 1'b1;
    step();
    imem_ready_in = 1'b0;
    rst_in        = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async got=%b/%h exp=0/0",
               imem_req_out, imem_addr_out);
    end
    step();
    rst_in         = 1'b1;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'h7777_7777;
    step();
    step();
    imem_rvalid_in = 1'b0;
    #1;
    checks++;
    if (instr_valid_out !== 1'b0 || instr_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst_late got=%b/%h exp=0/0",
               instr_valid_out, instr_out);
    end
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst_refetch got=%b/%h exp=1/0",
               imem_req_out, imem_addr_out);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_flush_wait();
    test_priority();
    test_misaligned();
    test_wrap();
    test_boot_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 BOOT_ADDR, 32'h0000_0000, first fetch address after reset and on a BOOT redirect.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 pc_src_in  input  2  PC source: 00 BOOT, 01 NEXT, 10 TRAP, 11 EPC; sampled only when flush_in=1.
REQ-005 flush_in  input  1  redirect request from machine control.
REQ-006 trap_vector_in  input  32  TRAP redirect target.
REQ-007 epc_in  input  32  EPC redirect target.
REQ-008 branch_taken_in  input  1  execute-stage redirect.
REQ-009 branch_target_in  input  32  branch/jump target.
REQ-010 stall_in  input  1  decode not ready; holds the output register.
REQ-011 imem_req_out  output  1  instruction-memory request valid.
REQ-012 imem_addr_out  output  32  request address; equals pc_out_next (current fetch PC).
REQ-013 imem_ready_in  input  1  memory accepts request this cycle.
REQ-014 imem_rvalid_in  input  1  read data valid.
REQ-015 imem_rdata_in  input  32  read data.
REQ-016 instr_out  output  32  fetched instruction (IF/ID register).
REQ-017 pc_out  output  32  PC of instr_out.
REQ-018 instr_valid_out  output  1  instr_out/pc_out valid.
REQ-019 misaligned_instr_out  output  1  fetch PC not word-aligned; level, held.

Function
REQ-020 State machine SHALL have states BOOT, REQ, WAIT, FAULT; fetch PC register fpc SHALL be 32 bits.
REQ-021 BOOT: fpc<=BOOT_ADDR, no request, exactly one cycle, then REQ.
REQ-022 REQ: if fpc[1:0]!=0 -> FAULT, no request; else imem_req_out=1 only when output register is free (instr_valid_out=0 or stall_in=0); transition to WAIT on the cycle imem_req_out & imem_ready_in.
REQ-023 imem_req_out and imem_addr_out SHALL be held stable until accepted; at most one request outstanding.
REQ-024 WAIT: on imem_rvalid_in with no pending kill: instr_out<=imem_rdata_in, pc_out<=fpc, instr_valid_out<=1, fpc<=fpc+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0), next state REQ.
REQ-025 Best-case throughput: one instruction per two cycles; rvalid in cycle after accept gives instr_valid_out 2 cycles after request.
REQ-026 Output register: when instr_valid_out=1 and stall_in=1, instr_out/pc_out/instr_valid_out SHALL hold; when stall_in=0 and no new instruction is loaded, instr_valid_out<=0.
REQ-027 Redirect priority: flush_in > branch_taken_in > sequential; flush target by pc_src_in: BOOT->BOOT_ADDR, TRAP->trap_vector_in, EPC->epc_in, NEXT->fpc unchanged.
REQ-028 On redirect: fpc<=target, instr_valid_out<=0 next cycle (regardless of stall_in), misaligned_instr_out<=0, state->REQ (from any state except BOOT).
REQ-029 Redirect while in WAIT: kill flag set; the outstanding response SHALL be discarded (no output load), kill cleared on that rvalid, then REQ issues at the new fpc; redirect and rvalid in same cycle discard that response.
REQ-030 Redirect while imem_req_out=1 not yet accepted: address SHALL change to new target next cycle (request withdrawn, no kill needed).
REQ-031 FAULT: misaligned_instr_out=1, no requests, instr_valid_out=0; exit only by redirect.
REQ-032 flush_in during BOOT SHALL be ignored.
REQ-033 imem_rvalid_in outside WAIT SHALL be ignored.

Reset
REQ-034 rst_in=0 asynchronously: state BOOT, fpc=BOOT_ADDR, imem_req_out=0, instr_valid_out=0, misaligned_instr_out=0, instr_out=0, pc_out=0, kill=0, imem_addr_out=BOOT_ADDR.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request; late rvalid after reset SHALL be ignored.

Verification
REQ-036 Reset release, ready=1, rvalid one cycle after accept, data 0x00000013 -> addr 0x0 then 0x4; instr_out=0x13, pc_out=0x0, valid 2 cycles after first request.
REQ-037 stall_in=1 for 3 cycles with valid output -> instr_out/pc_out unchanged, no new imem_req_out; release -> next request at pc_out+4.
REQ-038 flush_in=1, pc_src_in=10, trap_vector_in=0x100 while in WAIT -> pending rdata discarded, instr_valid_out=0, next request addr 0x100.
REQ-039 flush_in and branch_taken_in same cycle (epc_in=0x200, pc_src=11, target 0x300) -> next addr 0x200.
REQ-040 branch_target_in=0x102 -> misaligned_instr_out=1, no request; flush to BOOT -> flag clears, fetch at BOOT_ADDR.
REQ-041 fpc=0xFFFFFFFC fetched -> next request addr 0x00000000.
